// File: rtl/fifo_poly_collector_pkg.sv
// fifo_poly_collector_pkg: shared types and default sizes for the polynomial collector
package fifo_poly_collector_pkg;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_READ_SIZE = 4;
  localparam int DEF_POLY_LEN  = 256;
  typedef enum logic {COLLECT, PRESENT} collect_state_e;
endpackage

// File: rtl/fifo_poly_collector_if.sv
// fifo_poly_collector_if: FIFO read side plus polynomial handoff bundle
interface fifo_poly_collector_if
  import fifo_poly_collector_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int READ_SIZE = DEF_READ_SIZE,
  parameter int POLY_LEN  = DEF_POLY_LEN
) ();
  localparam int BEATS = POLY_LEN / READ_SIZE;
  localparam int CNT_W = $clog2(BEATS + 1);
  logic                            valid_i;
  logic [READ_SIZE-1:0][WIDTH-1:0] data_i;
  logic                            yumi_o;
  logic                            flush_i;
  logic                            poly_valid_o;
  logic [POLY_LEN-1:0][WIDTH-1:0]  poly_o;
  logic                            poly_ready_i;
  logic [CNT_W-1:0]                beat_cnt_o;
  modport slave (
    input  valid_i, data_i, flush_i, poly_ready_i,
    output yumi_o, poly_valid_o, poly_o, beat_cnt_o
  );
  modport master (
    output valid_i, data_i, flush_i, poly_ready_i,
    input  yumi_o, poly_valid_o, poly_o, beat_cnt_o
  );
endinterface

// File: rtl/fifo_poly_collector.sv
// fifo_poly_collector: pops READ_SIZE-word chunks from a FIFO and presents one full polynomial at a time
module fifo_poly_collector
  import fifo_poly_collector_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int READ_SIZE = DEF_READ_SIZE,
  parameter int POLY_LEN  = DEF_POLY_LEN
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  fifo_poly_collector_if.slave bus
);
  localparam int BEATS = POLY_LEN / READ_SIZE;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int IDX_W = $clog2(POLY_LEN);
  if (POLY_LEN % READ_SIZE != 0) begin : g_len_chk
    $error("POLY_LEN must be a multiple of READ_SIZE");
  end
  collect_state_e                 state_q, state_d;
  logic [CNT_W-1:0]               beat_q, beat_d;
  logic                           poly_valid_q, poly_valid_d;
  logic [POLY_LEN-1:0][WIDTH-1:0] poly_q, poly_d;
  logic                           yumi;
  logic [IDX_W-1:0]               base;
  assign yumi = (state_q == COLLECT) & bus.valid_i & ~bus.flush_i & ~reset_i;
  assign base = IDX_W'(beat_q) * IDX_W'(READ_SIZE);
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    poly_valid_d = poly_valid_q;
    poly_d       = poly_q;
    if (bus.flush_i || (state_q == PRESENT && bus.poly_ready_i)) begin
      state_d      = COLLECT;
      beat_d       = '0;
      poly_valid_d = 1'b0;
    end else if (yumi) begin
      poly_d[base +: READ_SIZE] = bus.data_i;
      beat_d                    = beat_q + 1'b1;
      state_d                   = (beat_q == CNT_W'(BEATS - 1)) ? PRESENT : COLLECT;
      poly_valid_d              = (beat_q == CNT_W'(BEATS - 1));
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= COLLECT;
      beat_q       <= '0;
      poly_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      poly_valid_q <= poly_valid_d;
    end
  end
  // Data buffer carries no reset: only meaningful while poly_valid is high
  always_ff @(posedge clk_i) poly_q <= poly_d;
  assign bus.yumi_o       = yumi;
  assign bus.poly_valid_o = poly_valid_q;
  assign bus.poly_o       = poly_q;
  assign bus.beat_cnt_o   = beat_q;
endmodule

// File: tb/tb_fifo_poly_collector.sv
// tb_fifo_poly_collector: directed scenarios for the polynomial collector (POLY_LEN=8, READ_SIZE=2)
module tb_fifo_poly_collector;
  localparam int W  = 16;
  localparam int RS = 2;
  localparam int PL = 8;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int tests = 0;
  int fails = 0;
  int handoffs = 0;
  always #5 clk = ~clk;
  fifo_poly_collector_if #(.WIDTH(W), .READ_SIZE(RS), .POLY_LEN(PL)) bus ();
  fifo_poly_collector #(.WIDTH(W), .READ_SIZE(RS), .POLY_LEN(PL)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .bus(bus)
  );
  always @(posedge clk)
    if (!reset_i && !bus.flush_i && bus.poly_valid_o && bus.poly_ready_i) handoffs <= handoffs + 1;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [RS-1:0][W-1:0] chunk(input int a);
    chunk[0] = W'(a);
    chunk[1] = W'(a + 1);
  endfunction
  function automatic logic [PL-1:0][W-1:0] exp_poly(input int base);
    for (int k = 0; k < PL; k++) exp_poly[k] = W'(base + k);
  endfunction
  task automatic fill(input int base);
    for (int k = 0; k < 4; k++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = chunk(base + 2 * k);
      cyc();
    end
    bus.valid_i = 1'b0;
  endtask
  task automatic handoff();
    bus.valid_i = 1'b0;
    bus.poly_ready_i = 1'b1;
    cyc();
    bus.poly_ready_i = 1'b0;
  endtask
  task automatic test_reset();
    reset_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i = chunk(99);
    #1;
    tests++;
    if (bus.yumi_o !== 1'b0) begin fails++; $display("FAIL reset_yumi: got %b want 0", bus.yumi_o); end
    cyc();
    cyc();
    tests++;
    if (bus.yumi_o !== 1'b0 || bus.poly_valid_o !== 1'b0 || bus.beat_cnt_o !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: yumi=%b pv=%b beat=%0d want 0,0,0", bus.yumi_o, bus.poly_valid_o, bus.beat_cnt_o);
    end
    reset_i = 1'b0;
    bus.valid_i = 1'b0;
    cyc();
  endtask
  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      bus.valid_i = 1'b1;
      bus.data_i = chunk(1 + 2 * k);
      #1;
      tests++;
      if (bus.yumi_o !== 1'b1 || bus.beat_cnt_o !== 3'(k)) begin
        fails++;
        $display("FAIL fill_beat%0d: yumi=%b beat=%0d want 1,%0d", k, bus.yumi_o, bus.beat_cnt_o, k);
      end
      cyc();
    end
    tests++;
    if (bus.poly_valid_o !== 1'b1 || bus.beat_cnt_o !== 3'd4 || bus.poly_o !== exp_poly(1)) begin
      fails++;
      $display("FAIL fill_present: pv=%b beat=%0d poly=%h want 1,4,%h", bus.poly_valid_o, bus.beat_cnt_o, bus.poly_o, exp_poly(1));
    end
  endtask
  task automatic test_hold();
    bus.valid_i = 1'b1;
    bus.data_i = chunk(50);
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (bus.yumi_o !== 1'b0 || bus.poly_valid_o !== 1'b1 || bus.poly_o !== exp_poly(1) || bus.beat_cnt_o !== 3'd4) begin
        fails++;
        $display("FAIL hold_c%0d: yumi=%b pv=%b beat=%0d poly=%h want 0,1,4,%h", c, bus.yumi_o, bus.poly_valid_o, bus.beat_cnt_o, bus.poly_o, exp_poly(1));
      end
      cyc();
    end
    bus.poly_ready_i = 1'b1;
    cyc();
    bus.poly_ready_i = 1'b0;
    #1;
    tests++;
    if (bus.poly_valid_o !== 1'b0 || bus.beat_cnt_o !== 3'd0 || bus.yumi_o !== 1'b1) begin
      fails++;
      $display("FAIL hold_handoff: pv=%b beat=%0d yumi=%b want 0,0,1", bus.poly_valid_o, bus.beat_cnt_o, bus.yumi_o);
    end
    bus.valid_i = 1'b0;
    cyc();
  endtask
  task automatic test_toggle();
    logic v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int n = 0;
    for (int i = 0; i < 7; i++) begin
      bus.valid_i = v[i];
      bus.data_i = v[i] ? chunk(11 + 2 * n) : chunk(77);
      #1;
      tests++;
      if (bus.yumi_o !== v[i]) begin fails++; $display("FAIL toggle_yumi%0d: got %b want %b", i, bus.yumi_o, v[i]); end
      cyc();
      if (v[i]) n++;
      tests++;
      if (bus.beat_cnt_o !== 3'(n) || bus.poly_valid_o !== (n == 4)) begin
        fails++;
        $display("FAIL toggle_beat%0d: beat=%0d pv=%b want %0d,%b", i, bus.beat_cnt_o, bus.poly_valid_o, n, n == 4);
      end
    end
    tests++;
    if (bus.poly_o !== exp_poly(11)) begin fails++; $display("FAIL toggle_poly: got %h want %h", bus.poly_o, exp_poly(11)); end
    handoff();
  endtask
  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      bus.valid_i = 1'b1;
      bus.data_i = chunk(200 + 2 * k);
      cyc();
    end
    bus.flush_i = 1'b1;
    bus.data_i = chunk(204);
    #1;
    tests++;
    if (bus.yumi_o !== 1'b0) begin fails++; $display("FAIL flush_yumi: got %b want 0", bus.yumi_o); end
    cyc();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    tests++;
    if (bus.beat_cnt_o !== 3'd0 || bus.poly_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_beat: beat=%0d pv=%b want 0,0", bus.beat_cnt_o, bus.poly_valid_o);
    end
    fill(31);
    tests++;
    if (bus.poly_valid_o !== 1'b1 || bus.poly_o !== exp_poly(31)) begin
      fails++;
      $display("FAIL flush_poly: pv=%b poly=%h want 1,%h", bus.poly_valid_o, bus.poly_o, exp_poly(31));
    end
    handoff();
  endtask
  task automatic test_reset_present();
    fill(61);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    tests++;
    if (bus.poly_valid_o !== 1'b0 || bus.beat_cnt_o !== 3'd0) begin
      fails++;
      $display("FAIL rstp_state: pv=%b beat=%0d want 0,0", bus.poly_valid_o, bus.beat_cnt_o);
    end
    bus.valid_i = 1'b1;
    bus.data_i = chunk(71);
    #1;
    tests++;
    if (bus.yumi_o !== 1'b1) begin fails++; $display("FAIL rstp_yumi: got %b want 1", bus.yumi_o); end
    cyc();
    bus.valid_i = 1'b0;
    tests++;
    if (bus.beat_cnt_o !== 3'd1) begin fails++; $display("FAIL rstp_beat: got %0d want 1", bus.beat_cnt_o); end
    bus.flush_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
  endtask
  task automatic test_flush_present();
    int h0;
    fill(81);
    h0 = handoffs;
    bus.flush_i = 1'b1;
    bus.poly_ready_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
    bus.poly_ready_i = 1'b0;
    tests++;
    if (bus.poly_valid_o !== 1'b0 || bus.beat_cnt_o !== 3'd0 || handoffs !== h0) begin
      fails++;
      $display("FAIL flushp_state: pv=%b beat=%0d handoffs=%0d want 0,0,%0d", bus.poly_valid_o, bus.beat_cnt_o, handoffs, h0);
    end
    bus.valid_i = 1'b1;
    bus.data_i = chunk(91);
    #1;
    tests++;
    if (bus.yumi_o !== 1'b1) begin fails++; $display("FAIL flushp_yumi: got %b want 1", bus.yumi_o); end
    bus.valid_i = 1'b0;
    cyc();
    tests++;
    if (handoffs !== 3) begin fails++; $display("FAIL handoff_total: got %0d want 3", handoffs); end
  endtask
  initial begin
    bus.valid_i = 1'b0;
    bus.data_i = '0;
    bus.flush_i = 1'b0;
    bus.poly_ready_i = 1'b0;
    test_reset();
    test_fill();
    test_hold();
    test_toggle();
    test_flush();
    test_reset_present();
    test_flush_present();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
